// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and opcode values.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_samp.sv
// One-bit full adder used as the bit-slice of the serial ALU.
module full_adder_samp (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    // Plain combinational sum and majority carry.
    always_comb begin
        sum   = a_in ^ b_in ^ c_in;
        c_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
    end

endmodule

// File: rtl/serial_alu_add_ctrl.sv
// Bit-serial add/subtract sequencer: shifts the operands LSB-first through one
// shared full adder and reports result, carry and overflow with a done pulse.
module serial_alu_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             op_sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             c_out,
    output logic             ovf_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;
    logic               load;
    logic               last_bit;

    // Operands are accepted from IDLE, or from DONE for back-to-back operation.
    assign load     = start_in && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (state == ST_RUN) && (cnt == LAST_CNT);

    full_adder_samp u_fa (
        .a_in  (a_sh[0]),
        .b_in  (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; busy/done are decoded from the registered state only.
    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_in) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_out = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_out   = 1'b1;
                state_next = start_in ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand load, per-bit shifting and the result capture on the final bit.
    // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_sh       <= '0;
            b_sh       <= '0;
            s_sh       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            result_out <= '0;
            c_out      <= 1'b0;
            ovf_out    <= 1'b0;
        end else if (load) begin
            a_sh  <= a_in;
            b_sh  <= (op_sub_in == ALU_OP_SUB) ? ~b_in : b_in;
            carry <= (op_sub_in == ALU_OP_SUB);
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                result_out <= {fa_sum, s_sh[WIDTH-1:1]};
                c_out      <= fa_cout;
                ovf_out    <= fa_cout ^ carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_add_ctrl.sv
// Directed and exhaustive checks for the bit-serial add/subtract sequencer.
module tb_serial_alu_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op_sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       c;
    logic       ovf;

    int checkCount = 0;
    int failCount  = 0;

    serial_alu_add_ctrl #(.WIDTH(4)) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .start_in   (start),
        .op_sub_in  (op_sub),
        .a_in       (a),
        .b_in       (b),
        .busy_out   (busy),
        .done_out   (done),
        .result_out (result),
        .c_out      (c),
        .ovf_out    (ovf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one start request, sampled on the next rising edge.
    // Returns at the falling edge right after the accepting edge.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                                 input logic sub);
        start  = 1'b1;
        a      = av;
        b      = bv;
        op_sub = sub;
        @(negedge clk);
        start  = 1'b0;
        a      = 4'hX;
        b      = 4'hX;
        op_sub = 1'bX;
    endtask

    // Wait (bounded) for done; report edges taken, busy samples and
    // whether the result moved before done.
    task automatic waitDone(output int lat, output int busyCnt, output bit moved);
        logic [3:0] held;
        held    = result;
        lat     = 0;
        busyCnt = 0;
        moved   = 1'b0;
        while (!done && lat < 20) begin
            if (busy) busyCnt++;
            if (result !== held) moved = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    // Independent reference: two's-complement add/subtract on 4 bits.
    function automatic logic [5:0] refModel(input logic [3:0] av, input logic [3:0] bv,
                                            input logic sub);
        logic [4:0] wide;
        logic [3:0] bEff;
        logic       ov;
        bEff = sub ? ~bv : bv;
        wide = {1'b0, av} + {1'b0, bEff} + {4'b0, sub};
        ov   = (av[3] == bEff[3]) && (wide[3] != av[3]);
        return {wide[4], ov, wide[3:0]};
    endfunction

    int  lat;
    int  busyCnt;
    int  doneCnt;
    bit  moved;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = 4'h0;
        b      = 4'h0;
        #12;
        checkOutput("reset_busy",   {31'b0, busy},   32'd0);
        checkOutput("reset_done",   {31'b0, done},   32'd0);
        checkOutput("reset_result", {28'b0, result}, 32'd0);
        checkOutput("reset_c",      {31'b0, c},      32'd0);
        checkOutput("reset_ovf",    {31'b0, ovf},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5 + 3: 8 with signed overflow.
        applyStimulus(4'd5, 4'd3, 1'b0);
        waitDone(lat, busyCnt, moved);
        checkOutput("add53_latency", lat, 32'd4);
        checkOutput("add53_busy",    busyCnt, 32'd4);
        checkOutput("add53_stable",  {31'b0, moved}, 32'd0);
        checkOutput("add53_out",     {26'b0, c, ovf, result}, {26'b0, 1'b0, 1'b1, 4'b1000});
        @(negedge clk);
        checkOutput("add53_done_pulse", {31'b0, done}, 32'd0);

        // F + 1: wraps with carry, no overflow.
        applyStimulus(4'hF, 4'h1, 1'b0);
        waitDone(lat, busyCnt, moved);
        checkOutput("addF1_out", {26'b0, c, ovf, result}, {26'b0, 1'b1, 1'b0, 4'h0});
        @(negedge clk);

        // 3 - 5: -2 with borrow.
        applyStimulus(4'd3, 4'd5, 1'b1);
        waitDone(lat, busyCnt, moved);
        checkOutput("sub35_out", {26'b0, c, ovf, result}, {26'b0, 1'b0, 1'b0, 4'hE});
        @(negedge clk);

        // 8 - 1: signed overflow, no borrow.
        applyStimulus(4'h8, 4'h1, 1'b1);
        waitDone(lat, busyCnt, moved);
        checkOutput("sub81_out", {26'b0, c, ovf, result}, {26'b0, 1'b1, 1'b1, 4'h7});
        @(negedge clk);

        // A second start during RUN must be ignored.
        applyStimulus(4'h2, 4'h2, 1'b0);
        applyStimulus(4'h1, 4'h1, 1'b0);
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) doneCnt++;
            if (done) checkOutput("ignore_result", {28'b0, result}, 32'h4);
            @(negedge clk);
        end
        checkOutput("ignore_done_count", doneCnt, 32'd1);

        // Back-to-back: restart in the DONE cycle.
        applyStimulus(4'h1, 4'h2, 1'b0);
        waitDone(lat, busyCnt, moved);
        checkOutput("b2b_first_out", {28'b0, result}, 32'h3);
        applyStimulus(4'h6, 4'h7, 1'b0);
        checkOutput("b2b_no_idle", {31'b0, busy}, 32'd1);
        waitDone(lat, busyCnt, moved);
        checkOutput("b2b_latency", lat + 1, 32'd5);
        checkOutput("b2b_out", {26'b0, c, ovf, result}, {26'b0, 1'b0, 1'b1, 4'hD});
        @(negedge clk);

        // Reset mid-RUN after two bits.
        applyStimulus(4'h5, 4'h4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",   {31'b0, busy},   32'd0);
        checkOutput("midrst_done",   {31'b0, done},   32'd0);
        checkOutput("midrst_result", {28'b0, result}, 32'd0);
        checkOutput("midrst_flags",  {30'b0, c, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) doneCnt++;
            @(negedge clk);
        end
        checkOutput("midrst_no_done", doneCnt, 32'd0);
        applyStimulus(4'h1, 4'h1, 1'b0);
        waitDone(lat, busyCnt, moved);
        checkOutput("post_rst_latency", lat, 32'd4);
        checkOutput("post_rst_out", {26'b0, c, ovf, result}, {26'b0, 1'b0, 1'b0, 4'h2});
        @(negedge clk);

        // Every operand pair under both operations against the model.
        for (int op = 0; op < 2; op++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    applyStimulus(4'(ai), 4'(bi), 1'(op));
                    waitDone(lat, busyCnt, moved);
                    checkOutput($sformatf("exh_%0d_%0h_%0h", op, ai, bi),
                                {lat[7:0], 18'b0, c, ovf, result},
                                {8'd4, 18'b0, refModel(4'(ai), 4'(bi), 1'(op))});
                    @(negedge clk);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
